// File: rtl/bcd_pkg.sv
// Shared types and helpers for the shared BCD-to-binary converter.
// Holds FSM state encoding, digit limits and the operand-wide BCD validity check.
package bcd_pkg;

  localparam int NDIG_DEF  = 4;
  localparam int OUT_W_DEF = 16;
  localparam int OP_MAXW   = 64;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CONV  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Operand is passed zero-extended; only the low ndig nibbles are inspected.
  function automatic logic is_bcd_word(input logic [OP_MAXW-1:0] op, input int ndig);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < OP_MAXW / 4; i++) begin
      if (i < ndig && op[4*i +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_horner_dp.sv
// Operand latch, accumulator and digit counter for MS-digit-first Horner conversion.
// One digit per step_i; acc_nxt_o is the combinational next accumulator value.
module bcd_horner_dp
  import bcd_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [4*NDIG-1:0] op_i,
  output logic              last_o,
  output logic              bad_o,
  output logic [OUT_W-1:0]  acc_nxt_o
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [4*NDIG-1:0] op_q;
  logic [OUT_W-1:0]  acc_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        digit;

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == CW'(i)) digit = op_q[4*i +: 4];
    end
  end

  // x*10 as (x<<3)+(x<<1); wraps modulo 2^OUT_W for wide operands.
  assign acc_nxt_o = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit);
  assign last_o    = (cnt_q == '0);
  assign bad_o     = !is_bcd_word(OP_MAXW'(op_q), NDIG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) op_q <= op_i;
      if (clr_i) begin
        acc_q <= '0;
        cnt_q <= CW'(NDIG - 1);
      end else if (step_i) begin
        acc_q <= acc_nxt_o;
        if (!last_o) cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shares one BCD-to-binary converter between two 4-phase requesters.
// done after NDIG+2 edges (2 if invalid), held until owner drops req; other req waits for IDLE.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int NDIG    = NDIG_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [4*NDIG-1:0] bcd0,
  input  logic              req1,
  input  logic [4*NDIG-1:0] bcd1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [OUT_W-1:0]  bin_o,
  output logic              err_o,
  output logic              busy
);

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               prio_q, prio_d;
  logic [OUT_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               sel, load, clr, step, last, bad, owner_req;
  logic [4*NDIG-1:0]  op_sel;
  logic [OUT_W-1:0]   acc_nxt;

  assign op_sel    = sel ? bcd1 : bcd0;
  assign owner_req = |(gnt_q & {req1, req0});

  bcd_horner_dp #(
    .NDIG  (NDIG),
    .OUT_W (OUT_W)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .clr_i     (clr),
    .step_i    (step),
    .op_i      (op_sel),
    .last_o    (last),
    .bad_o     (bad),
    .acc_nxt_o (acc_nxt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    bin_d   = bin_q;
    err_d   = err_q;
    sel     = 1'b0;
    load    = 1'b0;
    clr     = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel     = (req0 && req1) ? prio_q : req1;
          load    = 1'b1;
          gnt_d   = sel ? 2'b10 : 2'b01;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bad) begin
          err_d   = 1'b1;
          bin_d   = '0;
          state_d = DONE;
        end else begin
          clr     = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (last) begin
          bin_d   = acc_nxt;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Priority passes to whoever was not just served.
        if (!owner_req) begin
          gnt_d   = 2'b00;
          prio_d  = gnt_q[0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      prio_q  <= RR_INIT;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = (state_q == DONE) ? gnt_q : 2'b00;
  assign bin_o = bin_q;
  assign err_o = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized two-requester traffic against a decimal-arithmetic reference model.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] bcd0, bcd1;
  logic [1:0]  gnt, done;
  logic [15:0] bin_o;
  logic        err_o, busy;

  int n_chk  = 0;
  int n_pass = 0;
  int prio_m = 0;

  bcd_conv_arbiter #(.NDIG(4), .OUT_W(16), .RR_INIT(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .bcd0  (bcd0),
    .req1  (req1),
    .bcd1  (bcd1),
    .gnt   (gnt),
    .done  (done),
    .bin_o (bin_o),
    .err_o (err_o),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic [15:0] op;
    logic [15:0] eb;
    logic        ee;
    int          el;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [1:0] oh(input int w);
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic set_req(input int w, input logic v);
    if (w == 0) req0 = v; else req1 = v;
  endtask

  task automatic set_op(input int w, input logic [15:0] op);
    if (w == 0) bcd0 = op; else bcd1 = op;
  endtask

  // Reference: value = sum(digit_i * 10^i); any digit above 9 flags an error.
  task automatic ref_conv(input logic [15:0] op, output logic [15:0] b, output logic e);
    int v;
    int nib;
    v = 0;
    e = 1'b0;
    for (int d = 0; d < 4; d++) begin
      nib = int'((op >> (4*d)) & 16'hF);
      if (nib > 9) e = 1'b1;
      v += nib * (10 ** d);
    end
    b = e ? 16'd0 : 16'(v);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'd0;
    if ($urandom_range(0, 3) == 0) r = 16'($urandom);
    else for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Called at a negedge with requests already applied; returns at the negedge where done is seen.
  task automatic serve(input int w, input logic [15:0] eb, input logic ee, input int el,
                       input bit scramble);
    int lat;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) begin
        chk("gnt_first", 32'(gnt), 32'(oh(w)));
        if (scramble) set_op(w, 16'($urandom));
      end
      if (done != 2'b00) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, el);
    chk("done", 32'(done), 32'(oh(w)));
    chk("bin_o", 32'(bin_o), 32'(eb));
    chk("err_o", 32'(err_o), 32'(ee));
  endtask

  task automatic drop(input logic [1:0] m);
    if (m[0]) req0 = 1'b0;
    if (m[1]) req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_drop", 32'(busy), 32'd0);
    chk("done_after_drop", 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bin", 32'(bin_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_n  = 1'b1;
    prio_m = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          w;
    logic        pend[2];
    logic [15:0] opv[2];
    logic [15:0] eb;
    logic        ee;
    bit          allow;

    tbl[0] = '{0, 16'h1234, 16'd1234, 1'b0, 6};
    tbl[1] = '{1, 16'h12A4, 16'd0,    1'b1, 2};
    tbl[2] = '{0, 16'h0000, 16'd0,    1'b0, 6};
    tbl[3] = '{1, 16'h9999, 16'd9999, 1'b0, 6};
    tbl[4] = '{0, 16'h0100, 16'd100,  1'b0, 6};
    tbl[5] = '{1, 16'hF000, 16'd0,    1'b1, 2};
    tbl[6] = '{0, 16'h000A, 16'd0,    1'b1, 2};
    tbl[7] = '{1, 16'h5067, 16'd5067, 1'b0, 6};
    tbl[8] = '{0, 16'h0009, 16'd9,    1'b0, 6};

    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    bcd0  = 16'd0;
    bcd1  = 16'd0;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      set_op(tbl[i].who, tbl[i].op);
      set_req(tbl[i].who, 1'b1);
      serve(tbl[i].who, tbl[i].eb, tbl[i].ee, tbl[i].el, 1'b0);
      drop(oh(tbl[i].who));
      prio_m = 1 - tbl[i].who;
    end

    // Simultaneous requests out of reset: requester 0 first, then 1, then priority back to 0.
    do_reset();
    bcd0 = 16'h0009; bcd1 = 16'h9999; req0 = 1'b1; req1 = 1'b1;
    serve(0, 16'd9, 1'b0, 6, 1'b0);
    drop(2'b01);
    serve(1, 16'd9999, 1'b0, 6, 1'b0);
    drop(2'b10);
    bcd0 = 16'h0001; bcd1 = 16'h0002; req0 = 1'b1; req1 = 1'b1;
    serve(0, 16'd1, 1'b0, 6, 1'b0);
    drop(2'b11);
    prio_m = 1;

    // Owner holds req past done: result stays, no re-conversion.
    bcd0 = 16'h1234; req0 = 1'b1;
    serve(0, 16'd1234, 1'b0, 6, 1'b0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_bin", 32'(bin_o), 32'd1234);
    end
    drop(2'b01);

    // Asynchronous reset mid-conversion, then a fresh full conversion.
    bcd0 = 16'h4321; req0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_in_conv", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {27'd0, gnt, done, busy}, 32'd0);
    chk("arst_bin", 32'(bin_o), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    prio_m = 0;
    serve(0, 16'd4321, 1'b0, 6, 1'b0);
    drop(2'b01);

    // req1 held while req0 reissued each IDLE: grants alternate starting with 0.
    do_reset();
    bcd0 = 16'h0000; bcd1 = 16'h0100; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = prio_m;
      serve(w, (w == 1) ? 16'd100 : 16'd0, 1'b0, 6, 1'b0);
      if (k < 3) begin
        drop(oh(w));
        set_req(w, 1'b1);
      end else begin
        drop(2'b11);
      end
      prio_m = 1 - w;
    end

    // Randomized traffic; pending requests keep their operand until served.
    pend[0] = 1'b0; pend[1] = 1'b0;
    opv[0]  = 16'd0; opv[1]  = 16'd0;
    for (int it = 0; it < 60; it++) begin
      allow = (it < 48);
      if (allow) begin
        for (int r = 0; r < 2; r++) begin
          if (!pend[r] && $urandom_range(0, 1) == 1) begin
            pend[r] = 1'b1;
            opv[r]  = rand_op();
          end
        end
      end
      if (!pend[0] && !pend[1]) begin
        if (!allow) break;
        w       = int'($urandom_range(0, 1));
        pend[w] = 1'b1;
        opv[w]  = rand_op();
      end
      bcd0 = opv[0]; bcd1 = opv[1];
      req0 = pend[0]; req1 = pend[1];
      w = (pend[0] && pend[1]) ? prio_m : (pend[1] ? 1 : 0);
      ref_conv(opv[w], eb, ee);
      serve(w, eb, ee, ee ? 2 : 6, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        @(negedge clk);
        chk("rnd_hold_done", 32'(done), 32'(oh(w)));
      end
      drop(oh(w));
      pend[w] = 1'b0;
      prio_m  = 1 - w;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
